// File: rtl/calculator_alu.sv
// Registered N-bit integer ALU: ten arithmetic/logic/shift ops, 2N-bit result, NZCV flags.
// Division and modulo use an unrolled restoring divider, so every opcode has one-cycle latency.

module calculator_alu_div_stage #(
  parameter int Nbits = 4
) (
  input  logic [Nbits-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [Nbits-1:0] divisor,
  output logic [Nbits-1:0] rem_out,
  output logic             q_bit
);
  logic [Nbits:0] trial;

  assign trial   = {rem_in, dividend_bit};
  assign q_bit   = (trial >= {1'b0, divisor});
  // rem_in < divisor keeps the restored remainder inside Nbits
  assign rem_out = q_bit ? Nbits'(trial - {1'b0, divisor}) : trial[Nbits-1:0];
endmodule

module calculator_alu #(
  parameter int Nbits = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [3:0]         op_select,
  input  logic [Nbits-1:0]   operand1,
  input  logic [Nbits-1:0]   operand2,
  output logic [2*Nbits-1:0] resultado,
  output logic [3:0]         banderas
);
  localparam int W  = 2 * Nbits;
  localparam int W2 = 4 * Nbits;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  logic [Nbits:0]   sum;
  logic [Nbits-1:0] diff;
  logic [W-1:0]     prod;
  logic [31:0]      shamt;
  logic [W2-1:0]    shl_full;
  logic [Nbits-1:0] quot;
  logic [Nbits-1:0] rem_chain [Nbits+1];
  logic             b_zero;
  logic [W-1:0]     res;
  logic             c_flag, v_flag;

  assign sum      = {1'b0, operand1} + {1'b0, operand2};
  assign diff     = operand1 - operand2;
  assign prod     = W'(operand1) * W'(operand2);
  assign shamt    = 32'(operand2);
  // double-width shift keeps the bits pushed past W for the carry flag
  assign shl_full = W2'(operand1) << shamt;
  assign b_zero   = (operand2 == '0);

  assign rem_chain[0] = '0;
  for (genvar k = 0; k < Nbits; k++) begin : g_div
    calculator_alu_div_stage #(.Nbits(Nbits)) u_stage (
      .rem_in       (rem_chain[k]),
      .dividend_bit (operand1[Nbits-1-k]),
      .divisor      (operand2),
      .rem_out      (rem_chain[k+1]),
      .q_bit        (quot[Nbits-1-k])
    );
  end

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op_select)
      OP_ADD: begin
        res    = W'(sum);
        c_flag = sum[Nbits];
        v_flag = (operand1[Nbits-1] == operand2[Nbits-1]) && (sum[Nbits-1] != operand1[Nbits-1]);
      end
      OP_SUB: begin
        res    = {{Nbits{diff[Nbits-1]}}, diff};
        c_flag = (operand1 < operand2);
        v_flag = (operand1[Nbits-1] != operand2[Nbits-1]) && (diff[Nbits-1] != operand1[Nbits-1]);
      end
      OP_MUL: begin
        res    = prod;
        v_flag = |prod[W-1:Nbits];
      end
      OP_DIV: begin
        res    = b_zero ? '1 : W'(quot);
        v_flag = b_zero;
      end
      OP_MOD: begin
        res    = b_zero ? W'(operand1) : W'(rem_chain[Nbits]);
        v_flag = b_zero;
      end
      OP_AND: res = W'(operand1 & operand2);
      OP_OR:  res = W'(operand1 | operand2);
      OP_XOR: res = W'(operand1 ^ operand2);
      OP_SHL: begin
        if (shamt >= W) begin
          res    = '0;
          c_flag = |operand1;
        end else begin
          res    = shl_full[W-1:0];
          c_flag = |shl_full[W2-1:W];
        end
      end
      OP_SHR: res = W'(operand1 >> shamt);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      resultado <= '0;
      banderas  <= '0;
    end else begin
      resultado <= res;
      banderas  <= {res[W-1], (res == '0), c_flag, v_flag};
    end
  end
endmodule

// File: tb/tb_calculator_alu.sv
// Directed-vector bench for calculator_alu at Nbits=4 (8-bit result).
module tb_calculator_alu;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op_select = 4'd0;
  logic [3:0] operand1 = 4'd0;
  logic [3:0] operand2 = 4'd0;
  logic [7:0] resultado;
  logic [3:0] banderas;

  int total = 0;
  int bad   = 0;

  calculator_alu #(.Nbits(4)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .op_select (op_select),
    .operand1  (operand1),
    .operand2  (operand2),
    .resultado (resultado),
    .banderas  (banderas)
  );

  always #5 clock = ~clock;

  task automatic step(input vec_t t);
    op_select = t.op;
    operand1  = t.a;
    operand2  = t.b;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    op_select = 4'h0; operand1 = 4'h1; operand2 = 4'h1;
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({resultado, banderas} !== 12'h000) begin
      bad++;
      $display("FAIL reset_hold got res=%b flg=%b want res=00000000 flg=0000", resultado, banderas);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if ({resultado, banderas} !== {8'h02, 4'b0000}) begin
      bad++;
      $display("FAIL reset_first got res=%b flg=%b want res=00000010 flg=0000", resultado, banderas);
    end
  endtask

  task automatic test_addsub();
    vec_t v [4];
    v = '{'{4'h0, 4'h5, 4'h3, 8'h08, 4'b0001},
          '{4'h0, 4'hF, 4'h1, 8'h10, 4'b0010},
          '{4'h1, 4'h3, 4'h1, 8'h02, 4'b0000},
          '{4'h1, 4'h3, 4'h5, 8'hFE, 4'b1010}};
    for (int i = 0; i < 4; i++) begin
      step(v[i]);
      total++;
      if ({resultado, banderas} !== {v[i].r, v[i].f}) begin
        bad++;
        $display("FAIL addsub[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_muldiv();
    vec_t v [8];
    v = '{'{4'h2, 4'h3, 4'h3, 8'h09, 4'b0000},
          '{4'h2, 4'hF, 4'h3, 8'h2D, 4'b0001},
          '{4'h3, 4'h3, 4'h3, 8'h01, 4'b0000},
          '{4'h3, 4'hE, 4'h2, 8'h07, 4'b0000},
          '{4'h3, 4'h5, 4'h0, 8'hFF, 4'b1001},
          '{4'h4, 4'h3, 4'h3, 8'h00, 4'b0100},
          '{4'h4, 4'hF, 4'h2, 8'h01, 4'b0000},
          '{4'h4, 4'h7, 4'h0, 8'h07, 4'b0001}};
    for (int i = 0; i < 8; i++) begin
      step(v[i]);
      total++;
      if ({resultado, banderas} !== {v[i].r, v[i].f}) begin
        bad++;
        $display("FAIL muldiv[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v [5];
    v = '{'{4'h5, 4'hB, 4'h3, 8'h03, 4'b0000},
          '{4'h5, 4'hE, 4'h2, 8'h02, 4'b0000},
          '{4'h6, 4'hE, 4'h2, 8'h0E, 4'b0000},
          '{4'h7, 4'h3, 4'h3, 8'h00, 4'b0100},
          '{4'h7, 4'hE, 4'h2, 8'h0C, 4'b0000}};
    for (int i = 0; i < 5; i++) begin
      step(v[i]);
      total++;
      if ({resultado, banderas} !== {v[i].r, v[i].f}) begin
        bad++;
        $display("FAIL logic[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v [8];
    v = '{'{4'h8, 4'h3, 4'h3, 8'h18, 4'b0000},
          '{4'h8, 4'hE, 4'h2, 8'h38, 4'b0000},
          '{4'h8, 4'hF, 4'h5, 8'hE0, 4'b1010},
          '{4'h8, 4'h1, 4'hF, 8'h00, 4'b0110},
          '{4'h9, 4'h3, 4'h3, 8'h00, 4'b0100},
          '{4'h9, 4'hE, 4'h2, 8'h03, 4'b0000},
          '{4'h9, 4'hF, 4'h4, 8'h00, 4'b0100},
          '{4'hC, 4'h5, 4'h3, 8'h00, 4'b0100}};
    for (int i = 0; i < 8; i++) begin
      step(v[i]);
      total++;
      if ({resultado, banderas} !== {v[i].r, v[i].f}) begin
        bad++;
        $display("FAIL shift[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i].r, v[i].f);
      end
    end
  endtask

  // New inputs mid-cycle must not disturb the held result until the next edge.
  task automatic test_back_to_back();
    vec_t v [5];
    v = '{'{4'h0, 4'h2, 4'h2, 8'h04, 4'b0000},
          '{4'h2, 4'h7, 4'h7, 8'h31, 4'b0001},
          '{4'h1, 4'h0, 4'h1, 8'hFF, 4'b1010},
          '{4'h6, 4'h9, 4'h6, 8'h0F, 4'b0000},
          '{4'h3, 4'hF, 4'h4, 8'h03, 4'b0000}};
    step(v[0]);
    for (int i = 1; i < 5; i++) begin
      op_select = v[i].op; operand1 = v[i].a; operand2 = v[i].b;
      @(negedge clock);
      total++;
      if ({resultado, banderas} !== {v[i-1].r, v[i-1].f}) begin
        bad++;
        $display("FAIL b2b_hold[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i-1].r, v[i-1].f);
      end
      @(posedge clock);
      #1;
      total++;
      if ({resultado, banderas} !== {v[i].r, v[i].f}) begin
        bad++;
        $display("FAIL b2b_load[%0d] got res=%b flg=%b want res=%b flg=%b", i, resultado, banderas, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_mid_reset();
    step('{4'h0, 4'hF, 4'h1, 8'h10, 4'b0010});
    op_select = 4'h2; operand1 = 4'hF; operand2 = 4'hF;
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    total++;
    if ({resultado, banderas} !== 12'h000) begin
      bad++;
      $display("FAIL midrst_async got res=%b flg=%b want res=00000000 flg=0000", resultado, banderas);
    end
    @(posedge clock);
    #1;
    total++;
    if ({resultado, banderas} !== 12'h000) begin
      bad++;
      $display("FAIL midrst_hold got res=%b flg=%b want res=00000000 flg=0000", resultado, banderas);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if ({resultado, banderas} !== {8'hE1, 4'b1001}) begin
      bad++;
      $display("FAIL midrst_resume got res=%b flg=%b want res=11100001 flg=1001", resultado, banderas);
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_muldiv();
    test_logic();
    test_shift();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
